// File: rtl/dice_roll_engine.sv
// Dice roll engine: debounced die-select buttons, free-running LFSR face
// source and a small sequencer that sums one or more dice of the chosen type.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a debounced press; latches channel, sides, count, mode
// S_DRAW   | take a raw value (LFSR low byte, or S-1 in test mode)
// S_REDUCE | subtract S until the value is below S (one subtraction per cycle)
// S_ACCUM  | add face (value+1) to the running sum, count the die off
// S_DONE   | publish result/die_sel, pulse result_valid
module dice_roll_engine #(
  parameter int                 N_DIE           = 6,
  parameter logic [8*N_DIE-1:0] SIDES           = {8'd20, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4},
  parameter int                 MAX_DICE        = 4,
  parameter int                 DEBOUNCE_CYCLES = 500000,
  parameter int                 RESULT_W        = 8,
  localparam int                CH_W            = (N_DIE > 1) ? $clog2(N_DIE) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_DIE-1:0]    button,
  input  logic [2:0]          dice_count,
  input  logic                switch_test,
  output logic                busy,
  output logic [RESULT_W-1:0] result,
  output logic                result_valid,
  output logic [CH_W-1:0]     die_sel
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int               REM_W   = $clog2(MAX_DICE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_DRAW, S_REDUCE, S_ACCUM, S_DONE} state_t;

  logic [1:0]          rst_pipe_q;
  logic                rst_int_n;
  logic [N_DIE-1:0]    meta_q, sync_q, acc_q, press_q;
  logic [CNT_W-1:0]    cnt_q [N_DIE];
  logic [15:0]         lfsr_q;
  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d, ch_pick;
  logic [7:0]          s_q, s_d, r_q, r_d;
  logic [REM_W-1:0]    rem_q, rem_d, n_dice;
  logic                test_q, test_d;
  logic [RESULT_W-1:0] sum_q, sum_d, result_q, result_d;
  logic [CH_W-1:0]     die_sel_q, die_sel_d;

  // Reset sync: asserts immediately, releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_pipe_q <= 2'b00;
    else          rst_pipe_q <= {rst_pipe_q[0], 1'b1};
  end
  assign rst_int_n = rst_pipe_q[1];

  // Button synchroniser, debounce counters and rising-edge press pulses.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      meta_q  <= '0;
      sync_q  <= '0;
      acc_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < N_DIE; i++) cnt_q[i] <= '0;
    end else begin
      meta_q  <= button;
      sync_q  <= meta_q;
      press_q <= '0;
      for (int i = 0; i < N_DIE; i++) begin
        if (sync_q[i] != acc_q[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            acc_q[i]   <= sync_q[i];
            press_q[i] <= sync_q[i];
            cnt_q[i]   <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Free-running Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) lfsr_q <= 16'hACE1;
    else            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Lowest-numbered pressed channel wins.
  always_comb begin
    ch_pick = '0;
    for (int i = N_DIE - 1; i >= 0; i--) begin
      if (press_q[i]) ch_pick = CH_W'(i);
    end
  end

  // Dice count: 0 means one die, anything above MAX_DICE clamps.
  always_comb begin
    n_dice = REM_W'(MAX_DICE);
    if (dice_count == 3'd0)                n_dice = REM_ONE;
    else if (int'(dice_count) <= MAX_DICE) n_dice = REM_W'(dice_count);
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      s_q       <= '0;
      r_q       <= '0;
      rem_q     <= '0;
      test_q    <= 1'b0;
      sum_q     <= '0;
      result_q  <= '0;
      die_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      s_q       <= s_d;
      r_q       <= r_d;
      rem_q     <= rem_d;
      test_q    <= test_d;
      sum_q     <= sum_d;
      result_q  <= result_d;
      die_sel_q <= die_sel_d;
    end
  end

  // Next-state and datapath updates; result is loaded on the way into DONE
  // so it is already stable while result_valid is high.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    s_d       = s_q;
    r_d       = r_q;
    rem_d     = rem_q;
    test_d    = test_q;
    sum_d     = sum_q;
    result_d  = result_q;
    die_sel_d = die_sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (|press_q) begin
          ch_d    = ch_pick;
          s_d     = SIDES[int'(ch_pick)*8 +: 8];
          rem_d   = n_dice;
          test_d  = switch_test;
          sum_d   = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        r_d     = test_q ? (s_q - 8'd1) : lfsr_q[7:0];
        state_d = S_REDUCE;
      end
      S_REDUCE: begin
        if (r_q >= s_q) r_d = r_q - s_q;
        else            state_d = S_ACCUM;
      end
      S_ACCUM: begin
        sum_d = sum_q + RESULT_W'(r_q) + RESULT_W'(1);
        rem_d = rem_q - REM_ONE;
        if (rem_q == REM_ONE) begin
          result_d  = sum_d;
          die_sel_d = ch_q;
          state_d   = S_DONE;
        end else begin
          state_d = S_DRAW;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;
  assign die_sel      = die_sel_q;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed bench for dice_roll_engine with a short debounce time.
// Cycle k is the interval after rising edge k; buttons change just after an
// edge, so with DEBOUNCE_CYCLES=4 the press pulse lands 7 cycles later.
module tb_dice_roll_engine;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] button = '0;
  logic [2:0] dice_count = 3'd1;
  logic       switch_test = 1'b0;
  logic       busy;
  logic [7:0] result;
  logic       result_valid;
  logic [2:0] die_sel;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int valid_cnt = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  m_rs;

  dice_roll_engine #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button       (button),
    .dice_count   (dice_count),
    .switch_test  (switch_test),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .die_sel      (die_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (result_valid === 1'b1) valid_cnt++;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR: seed ACE1, starts stepping once reset release has passed
  // through the two-stage reset synchroniser.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rs   <= 2'b00;
      m_lfsr <= 16'hACE1;
    end else begin
      m_rs <= {m_rs[0], 1'b1};
      if (m_rs[1]) m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive buttons and roll settings, then wait (bounded) for result_valid.
  // Returns cycles from the raw edge to the valid cycle, or -1 on timeout.
  task automatic press_wait(input logic [5:0] mask, input int cnt, input bit tm, output int lat);
    int e;
    e = cyc;
    button = mask;
    dice_count = 3'(cnt);
    switch_test = tm;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        lat = cyc - e;
        break;
      end
    end
  endtask

  task automatic finish_roll(input string tag);
    @(negedge clk);
    check_eq({tag, "_valid_single"}, int'(result_valid), 0);
    check_eq({tag, "_busy_fall"}, int'(busy), 0);
    @(posedge clk); #1;
    button = '0;
    repeat (9) @(posedge clk);
    #1;
  endtask

  task automatic directed_roll(input string tag, input logic [5:0] mask, input int cnt,
                               input int exp_res, input int exp_sel, input int exp_lat);
    int lat;
    press_wait(mask, cnt, 1'b1, lat);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_result"}, int'(result), exp_res);
    check_eq({tag, "_die_sel"}, int'(die_sel), exp_sel);
    finish_roll(tag);
  endtask

  logic [31:0] seen = '0;

  // D20 single-die random roll checked against the reference LFSR.
  task automatic rand_roll(input string tag);
    logic [15:0] v;
    int r0, face, k, lat, res;
    v = m_lfsr;
    for (int i = 0; i < 8; i++) v = lfsr_step(v);
    r0   = int'(v[7:0]);
    face = r0 % 20 + 1;
    k    = r0 / 20;
    press_wait(6'b100000, 1, 1'b0, lat);
    res = int'(result);
    check_eq({tag, "_latency"}, lat, 11 + k);
    check_eq({tag, "_face"}, res, face);
    check_eq({tag, "_range"}, int'(res >= 1 && res <= 20), 1);
    if (res >= 1 && res <= 20) seen = seen | (32'd1 << (res - 1));
    finish_roll(tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, lat;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_result", int'(result), 0);
    check_eq("rst_valid", int'(result_valid), 0);
    check_eq("rst_die_sel", int'(die_sel), 0);

    // Test mode: every face is S, valid at 7 + 3N + 1 after the raw edge.
    directed_roll("d4x1",   6'b000001, 1, 4,  0, 11);
    directed_roll("d6x2",   6'b000010, 2, 12, 1, 14);
    directed_roll("d6x0",   6'b000010, 0, 6,  1, 11);
    directed_roll("d6x7",   6'b000010, 7, 24, 1, 20);
    directed_roll("simul",  6'b100100, 1, 8,  2, 11);

    // Press on button 4 while a D20x4 roll is busy is dropped.
    v0 = valid_cnt;
    button = 6'b100000; dice_count = 3'd4; switch_test = 1'b1;
    repeat (3) @(posedge clk);
    #1 button = 6'b110000;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin lat = i; break; end
    end
    check_eq("busy_press_result", int'(result), 80);
    check_eq("busy_press_die_sel", int'(die_sel), 5);
    check_eq("busy_press_seen", int'(lat >= 0), 1);
    @(posedge clk); #1 button = '0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("busy_press_count", valid_cnt - v0, 1);

    // Short glitch never reaches the accepted level.
    v0 = valid_cnt;
    button = 6'b001000;
    repeat (3) @(posedge clk);
    #1 button = '0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("glitch_count", valid_cnt - v0, 0);
    check_eq("glitch_busy", int'(busy), 0);

    // Held button: one roll only.
    v0 = valid_cnt;
    press_wait(6'b000010, 1, 1'b1, lat);
    check_eq("held_latency", lat, 11);
    repeat (40) @(posedge clk);
    #1 button = '0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("held_count", valid_cnt - v0, 1);

    for (int n = 0; n < 1000; n++) rand_roll("d20_rand");
    check_eq("d20_all_faces", int'(seen), 32'h000F_FFFF);

    // Reset during the first REDUCE of a D12x4 test roll (cycle 9).
    v0 = valid_cnt;
    button = 6'b010000; dice_count = 3'd4; switch_test = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check_eq("mid_busy_before", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_result", int'(result), 0);
    check_eq("mid_rst_valid", int'(result_valid), 0);
    check_eq("mid_rst_die_sel", int'(die_sel), 0);
    check_eq("mid_rst_lfsr", int'(dut.lfsr_q), 16'hACE1);
    button = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_eq("mid_rst_no_valid", valid_cnt - v0, 0);
    for (int n = 0; n < 3; n++) rand_roll("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dice_roll_engine.md
# dice_roll_engine

Parametrised roll engine for the dice roller: debounces N die-select buttons, draws pseudo-random faces from a free-running LFSR, and sums a selectable number of dice of the chosen type. It is the next generation of the fixed six-button roll path in `diceTop`. Die-type count, face counts, dice-per-roll and debounce time are all parameters. It adds multi-dice rolls, a busy/valid handshake and a deterministic test mode. It sits between the raw board buttons and the display/BCD logic.

## Interface
- `N_DIE`, 6: number of die-select buttons/channels.
- `SIDES`, {8'd20,8'd12,8'd10,8'd8,8'd6,8'd4}: packed 8-bit face count per channel; channel 0 is the LSB byte (D4). Each entry must be 2..255.
- `MAX_DICE`, 4: maximum dice per roll.
- `DEBOUNCE_CYCLES`, 500000: stable cycles required before a button level is accepted. Must be ≥1.
- `RESULT_W`, 8: sum width. Must satisfy `2^RESULT_W > MAX_DICE*max(SIDES)`.
- `clk`, input, 1: single clock, all logic on rising edge.
- `reset_n`, input, 1: reset is asynchronous and active-low.
- `button`, input, N_DIE: raw, asynchronous, active-high die-select buttons.
- `dice_count`, input, 3: dice per roll, sampled at roll start.
- `switch_test`, input, 1: test mode, sampled at roll start.
- `busy`, output, 1: high from roll start through the DONE cycle.
- `result`, output, RESULT_W: sum of the last completed roll, held until the next DONE.
- `result_valid`, output, 1: one-cycle pulse in the DONE cycle.
- `die_sel`, output, clog2(N_DIE): channel of the last completed roll.

## Operation
- **Per-button input path:**
  - 2-flop synchroniser, then a debounce counter.
  - The counter increments while the synced level differs from the accepted level and clears when they match.
  - On reaching DEBOUNCE_CYCLES, the accepted level takes the synced level and the counter clears.
  - A 0→1 change of the accepted level produces a one-cycle `press` pulse.
- **LFSR:** 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1. Reset seed 16'hACE1. Steps every cycle, regardless of state.
- **FSM states:** IDLE, DRAW, REDUCE, ACCUM, DONE.
- **IDLE:**
  - On any `press` pulse, latch the channel index: lowest index wins on simultaneous pulses.
  - Latch S = SIDES[ch], the remaining-dice count and the mode; clear sum; go DRAW.
  - Count rule: `dice_count` 0 → 1; values above MAX_DICE clamp to MAX_DICE.
- **DRAW:**
  - r ← LFSR[7:0], or r ← S−1 in test mode.
  - → REDUCE.
- **REDUCE:**
  - If r ≥ S, r ← r−S and stay (one subtraction per cycle, at most 127 iterations).
  - Otherwise → ACCUM.
- **ACCUM:**
  - sum ← sum + r + 1; remaining ← remaining − 1.
  - → DRAW if remaining ≠ 0, else → DONE.
- **DONE:**
  - `result` ← sum, `die_sel` ← ch, `result_valid` = 1.
  - → IDLE.
- **Presses while busy:** `press` pulses outside IDLE are discarded, not queued. Debounce keeps running, so a button held through the roll must be released and re-pressed.
- **Face range:** each face is in 1..S. Sum is in count..count*S and never wraps, given the RESULT_W rule.

## Timing
- **Reset values:**
  - Outputs: `busy`=0, `result`=0, `result_valid`=0, `die_sel`=0.
  - Internal: FSM=IDLE, LFSR=16'hACE1, accepted levels=0, debounce counters=0.
- **Reset timing:** assertion is immediate, including mid-roll; the roll is aborted and no `result_valid` is produced. Deassertion is synchronous to `clk` via the standard reset sync.
- **Button to press:** a clean edge yields `press` 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the raw edge. A glitch shorter than DEBOUNCE_CYCLES yields no pulse.
- **Roll latency (press pulse in cycle 0):**
  - `busy` rises in cycle 1.
  - Per die: DRAW (1) + REDUCE (1+k subtractions) + ACCUM (1).
  - Test mode (k=0): DONE and `result_valid` in cycle 3N+1; `busy` falls in cycle 3N+2.
- **Back-to-back rolls:** IDLE accepts a new press in the cycle after DONE.

## Test plan
- D4 test mode: DEBOUNCE_CYCLES=4, `switch_test`=1, `dice_count`=1, pulse `button[0]` → `result`=4, `die_sel`=0, `result_valid` exactly 4 cycles after `press`, single-cycle.
- D6 ×2, test mode → `result`=12, `die_sel`=1, valid at cycle 7. `dice_count`=0 → `result`=6. `dice_count`=7 → `result`=24.
- D20 random mode, 1000 rolls with `dice_count`=1 → every result in 1..20, all 20 faces seen. Check against a reference model of the LFSR from seed ACE1.
- Simultaneous debounced presses of `button[2]` and `button[5]` → `die_sel`=2. Press `button[4]` while `busy` → no extra roll, a single `result_valid`.
- Bounce: 3-cycle high glitch on `button[3]` → no `press`. Held button → exactly one roll.
- Reset mid-roll (D12 ×4, `reset_n` low during REDUCE) → outputs immediately at reset values, no `result_valid`, LFSR restarts at ACE1.
